// File: rtl/i2c_arb_pkg.sv
// ============================================================================
// Module   : i2c_arb_pkg
// Brief    : State encoding and default register map for i2c_req_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_arb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_ARB     = 4'd1,
    ST_WR_DATA = 4'd2,
    ST_START   = 4'd3,
    ST_CLR     = 4'd4,
    ST_WAIT    = 4'd5,
    ST_POLL    = 4'd6,
    ST_SAMPLE  = 4'd7,
    ST_DONE    = 4'd8
  } state_t;

  localparam logic [3:0]  c_ADDR_DATA_DEF = 4'h2;
  localparam logic [3:0]  c_ADDR_CTRL_DEF = 4'h0;
  localparam logic [3:0]  c_ADDR_STAT_DEF = 4'h4;
  localparam logic [15:0] c_CTRL_START    = 16'h0001;
  localparam logic [15:0] c_CTRL_CLEAR    = 16'h0000;

endpackage

`default_nettype wire

// File: rtl/i2c_req_arbiter_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick, searching from i_ptr upward.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IW    = 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IW-1:0]    o_idx,
  output logic             o_valid
);

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      int k;
      k = int'(i_ptr) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (!o_valid && i_req[k]) begin
        o_valid  = 1'b1;
        o_idx    = IW'(k);
        o_gnt[k] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/i2c_req_arbiter.sv
// ============================================================================
// Module   : i2c_req_arbiter
// Brief    : Round-robin sharing of one I2C peripheral register bus among
//            N_REQ requesters. Optional abort on poll timeout: I2C_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int         N_REQ      = 2,
  parameter logic [3:0] ADDR_DATA  = c_ADDR_DATA_DEF,
  parameter logic [3:0] ADDR_CTRL  = c_ADDR_CTRL_DEF,
  parameter logic [3:0] ADDR_STAT  = c_ADDR_STAT_DEF,
  parameter int         BUSY_BIT   = 0,
  parameter int         START_WAIT = 4,
  parameter int         TIMEOUT    = 50000
) (
  input  logic                sys_clk_i,
  input  logic                sys_rst_i,
  input  logic [N_REQ-1:0]    req_i,
  input  logic [16*N_REQ-1:0] req_data_i,
  output logic [N_REQ-1:0]    gnt_o,
  output logic [N_REQ-1:0]    done_o,
  output logic                err_o,
  output logic [15:0]         per_d_in_o,
  output logic                per_cs_o,
  output logic [3:0]          per_addr_o,
  output logic                per_rd_o,
  output logic                per_wr_o,
  input  logic [7:0]          per_d_out_i
);

  localparam int IW = $clog2(N_REQ);

  state_t           r_state, w_next;
  logic [IW-1:0]    r_idx, r_ptr, w_idx;
  logic [N_REQ-1:0] r_gnt, w_gnt;
  logic             w_valid;
  logic [15:0]      r_data, w_sel;
  logic [15:0]      r_wait;
  logic             w_busy, w_wait_done, w_to_hit, w_err_wr;
  logic             w_unused;

  assign w_busy      = per_d_out_i[BUSY_BIT];
  assign w_wait_done = (r_wait == 16'(START_WAIT - 1));
  assign w_unused    = ^{per_d_out_i, 32'(TIMEOUT)};

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
    .i_req   (req_i),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  always_comb begin
    w_sel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_idx == IW'(k)) w_sel = req_data_i[16*k +: 16];
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  logic [15:0] r_to;
  logic        r_err;

  assign w_to_hit = (r_to == 16'(TIMEOUT - 1));
  assign w_err_wr = r_err;

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_to  <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        ST_CLR:    r_to <= '0;
        ST_POLL: begin
          r_to <= r_to + 16'd1;
          if (w_to_hit) r_err <= 1'b1;
        end
        ST_SAMPLE: begin
          r_to <= r_to + 16'd1;
          // A clean status in the final poll still counts as success.
          if (w_to_hit && w_busy) r_err <= 1'b1;
        end
        ST_DONE:   r_err <= 1'b0;
        default: ;
      endcase
    end
  end
`else
  assign w_to_hit = 1'b0;
  assign w_err_wr = 1'b0;
`endif

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_data  <= '0;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_ARB: begin
          if (w_valid) begin
            r_idx  <= w_idx;
            r_gnt  <= w_gnt;
            r_data <= w_sel;
          end
        end
        ST_CLR:  r_wait <= '0;
        ST_WAIT: r_wait <= r_wait + 16'd1;
        ST_DONE: begin
          r_gnt <= '0;
          r_ptr <= (r_idx == IW'(N_REQ - 1)) ? '0 : r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next     = r_state;
    per_cs_o   = 1'b0;
    per_wr_o   = 1'b0;
    per_rd_o   = 1'b0;
    per_addr_o = '0;
    per_d_in_o = '0;
    case (r_state)
      ST_IDLE:    if (|req_i) w_next = ST_ARB;
      ST_ARB:     w_next = w_valid ? ST_WR_DATA : ST_IDLE;
      ST_WR_DATA: begin
        per_cs_o   = 1'b1;
        per_wr_o   = 1'b1;
        per_addr_o = ADDR_DATA;
        per_d_in_o = r_data;
        w_next     = ST_START;
      end
      ST_START: begin
        per_cs_o   = 1'b1;
        per_wr_o   = 1'b1;
        per_addr_o = ADDR_CTRL;
        per_d_in_o = c_CTRL_START;
        w_next     = ST_CLR;
      end
      ST_CLR: begin
        per_cs_o   = 1'b1;
        per_wr_o   = 1'b1;
        per_addr_o = ADDR_CTRL;
        per_d_in_o = c_CTRL_CLEAR;
        w_next     = ST_WAIT;
      end
      ST_WAIT:    if (w_wait_done) w_next = ST_POLL;
      ST_POLL: begin
        per_cs_o   = 1'b1;
        per_rd_o   = 1'b1;
        per_addr_o = ADDR_STAT;
        w_next     = w_to_hit ? ST_DONE : ST_SAMPLE;
      end
      ST_SAMPLE:  w_next = (!w_busy || w_to_hit) ? ST_DONE : ST_POLL;
      ST_DONE: begin
        // After an abort, leave the peripheral with start cleared.
        if (w_err_wr) begin
          per_cs_o   = 1'b1;
          per_wr_o   = 1'b1;
          per_addr_o = ADDR_CTRL;
          per_d_in_o = c_CTRL_CLEAR;
        end
        w_next = ST_IDLE;
      end
      default:    w_next = ST_IDLE;
    endcase
  end

  assign gnt_o  = r_gnt;
  assign done_o = (r_state == ST_DONE) ? r_gnt : '0;
  assign err_o  = (r_state == ST_DONE) && w_err_wr;

endmodule

`default_nettype wire

// File: tb/tb_i2c_req_arbiter.sv
// ============================================================================
// Module   : tb_i2c_req_arbiter
// Brief    : Self-checking bench with behavioural peripheral and RR model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_req_arbiter;

  localparam int N  = 2;
  localparam int SW = 4;
  localparam int TO = 100;

  logic          sys_clk_i = 1'b0;
  logic          sys_rst_i = 1'b0;
  logic [N-1:0]  req_i = '0;
  logic [16*N-1:0] req_data_i = '0;
  logic [N-1:0]  gnt_o, done_o;
  logic          err_o, per_cs_o, per_rd_o, per_wr_o;
  logic [15:0]   per_d_in_o;
  logic [3:0]    per_addr_o;
  logic [7:0]    per_d_out_i = '0;

  i2c_req_arbiter #(.N_REQ(N), .START_WAIT(SW), .TIMEOUT(TO)) dut (
    .sys_clk_i   (sys_clk_i),
    .sys_rst_i   (sys_rst_i),
    .req_i       (req_i),
    .req_data_i  (req_data_i),
    .gnt_o       (gnt_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .per_d_in_o  (per_d_in_o),
    .per_cs_o    (per_cs_o),
    .per_addr_o  (per_addr_o),
    .per_rd_o    (per_rd_o),
    .per_wr_o    (per_wr_o),
    .per_d_out_i (per_d_out_i)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Peripheral: busy for b_cycles edges after a start write, or forever if stuck.
  int          b_cycles = 0;
  bit          stuck = 1'b0;
  int          busy_cnt = 0;
  int          rd_cnt = 0;
  int          n_done = 0;
  logic [19:0] wq[$];

  always @(posedge sys_clk_i) begin
    if (per_cs_o && per_wr_o) wq.push_back({per_addr_o, per_d_in_o});
    if (per_cs_o && per_wr_o && per_addr_o == 4'h0 && per_d_in_o[0])
      busy_cnt <= b_cycles;
    else if (busy_cnt != 0)
      busy_cnt <= busy_cnt - 1;
    if (per_cs_o && per_rd_o) begin
      rd_cnt      <= rd_cnt + 1;
      per_d_out_i <= {7'b0, (stuck || busy_cnt != 0)};
    end
  end

  always @(negedge sys_clk_i) begin
    if (done_o != '0) n_done <= n_done + 1;
    check("proto_wr_rd", 32'(per_wr_o & per_rd_o), 0);
    check("proto_cs_idle", 32'(~per_cs_o & (per_wr_o | per_rd_o)), 0);
    check("proto_gnt_onehot", 32'($onehot0(gnt_o)), 1);
    check("proto_done_gnt", 32'(|(done_o & ~gnt_o)), 0);
  end

  function automatic logic [31:0] all_outs();
    return {4'b0, gnt_o, done_o, err_o, per_cs_o, per_wr_o, per_rd_o, per_addr_o, per_d_in_o};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] p, input int ptr);
    for (int i = 0; i < N; i++) if (p[(ptr + i) % N]) return (ptr + i) % N;
    return 0;
  endfunction

  task automatic wait_done(input int limit, output logic [N-1:0] d, output logic e,
                           output int cyc, output logic [N-1:0] gs);
    d = '0; e = 1'b0; cyc = 0; gs = '0;
    while (d == '0 && cyc < limit) begin
      @(negedge sys_clk_i);
      cyc++;
      gs |= gnt_o;
      d = done_o;
      e = err_o;
    end
  endtask

  task automatic check_writes(input string tag, input int base, input logic [15:0] data);
    check({tag, "_nwr"}, 32'(wq.size() - base), 3);
    check({tag, "_w_data"}, 32'(wq[base]),     {12'h0, 4'h2, data});
    check({tag, "_w_start"}, 32'(wq[base + 1]), {12'h0, 4'h0, 16'h0001});
    check({tag, "_w_clr"}, 32'(wq[base + 2]),   {12'h0, 4'h0, 16'h0000});
  endtask

  int            m_ptr, exp_i, cyc, wb, rb, nd;
  logic [N-1:0]  d, gs, exp_oh, pending;
  logic          e;
  logic [15:0]   exp_data;

  initial begin
    repeat (3) @(negedge sys_clk_i);
    check("reset_outputs", all_outs(), 0);
    sys_rst_i = 1'b1;
    m_ptr = 0;

    // Single request, busy for 10 cycles
    b_cycles = 10;
    req_data_i = {16'h1234, 16'ha050};
    wb = wq.size(); nd = n_done;
    req_i = 2'b01;
    wait_done(300, d, e, cyc, gs);
    req_i = '0;
    check("t1_done", 32'(d), 32'h1);
    check("t1_err", 32'(e), 0);
    check("t1_gnt_seen", 32'(gs), 32'h1);
    check_writes("t1", wb, 16'ha050);
    repeat (3) @(negedge sys_clk_i);
    check("t1_one_done", 32'(n_done - nd), 1);
    m_ptr = 1;

    // Minimum latency with busy already clear
    b_cycles = 0;
    rb = rd_cnt;
    req_i = 2'b01;
    wait_done(300, d, e, cyc, gs);
    req_i = '0;
    check("t3_done", 32'(d), 32'h1);
    check("t3_latency", 32'(cyc), 32'(7 + SW));
    check("t3_polls", 32'(rd_cnt - rb), 1);
    m_ptr = 1;
    repeat (2) @(negedge sys_clk_i);

    // Both requesting continuously: grants must alternate
    b_cycles = 3;
    req_data_i = $urandom;
    req_i = 2'b11;
    for (int t = 0; t < 4; t++) begin
      exp_i = rr_pick(2'b11, m_ptr);
      exp_oh = '0; exp_oh[exp_i] = 1'b1;
      exp_data = req_data_i[16*exp_i +: 16];
      wb = wq.size();
      wait_done(300, d, e, cyc, gs);
      req_data_i = $urandom;
      check("t2_done", 32'(d), 32'(exp_oh));
      check("t2_gnt", 32'(gs), 32'(exp_oh));
      check_writes("t2", wb, exp_data);
      m_ptr = (exp_i + 1) % N;
    end
    req_i = '0;
    repeat (2) @(negedge sys_clk_i);

    // Randomized request patterns and busy lengths
    for (int r = 0; r < 12; r++) begin
      pending = N'($urandom_range(1, 3));
      b_cycles = $urandom_range(0, 6);
      req_data_i = $urandom;
      req_i = pending;
      for (int s = 0; s < N && pending != '0; s++) begin
        exp_i = rr_pick(pending, m_ptr);
        exp_oh = '0; exp_oh[exp_i] = 1'b1;
        exp_data = req_data_i[16*exp_i +: 16];
        wb = wq.size();
        wait_done(300, d, e, cyc, gs);
        req_data_i = $urandom;
        check("rnd_done", 32'(d), 32'(exp_oh));
        check_writes("rnd", wb, exp_data);
        pending = pending & ~exp_oh;
        req_i = pending;
        m_ptr = (exp_i + 1) % N;
      end
      repeat ($urandom_range(1, 3)) @(negedge sys_clk_i);
    end

    // Reset while polling
    b_cycles = 1000;
    req_data_i = {16'h0000, 16'hbeef};
    req_i = 2'b01;
    cyc = 0;
    while (!per_rd_o && cyc < 100) begin
      @(negedge sys_clk_i);
      cyc++;
    end
    check("t4_reach_poll", 32'(per_rd_o), 1);
    sys_rst_i = 1'b0;
    #1;
    check("t4_rst_outputs", all_outs(), 0);
    b_cycles = 2;
    repeat (2) @(negedge sys_clk_i);
    nd = n_done;
    wb = wq.size();
    sys_rst_i = 1'b1;
    m_ptr = 0;
    wait_done(300, d, e, cyc, gs);
    req_i = '0;
    check("t4_done", 32'(d), 32'h1);
    check_writes("t4", wb, 16'hbeef);
    repeat (3) @(negedge sys_clk_i);
    check("t4_one_done", 32'(n_done - nd), 1);
    m_ptr = 1;

    // Busy stuck high
    stuck = 1'b1;
    req_data_i = {16'h5a5a, 16'h0000};
    rb = rd_cnt; wb = wq.size(); nd = n_done;
    req_i = 2'b10;
`ifdef I2C_ARB_TIMEOUT_EN
    wait_done(2 * TO + 50, d, e, cyc, gs);
    req_i = '0;
    check("t5_done", 32'(d), 32'h2);
    check("t5_err", 32'(e), 1);
    check("t5_polls", 32'(rd_cnt - rb), 32'(TO / 2));
    check("t5_ctrl_clear", 32'(wq[wq.size() - 1]), 0);
    check("t5_nwr", 32'(wq.size() - wb), 4);
`else
    repeat (10000) @(negedge sys_clk_i);
    check("t5_no_done", 32'(n_done - nd), 0);
    check("t5_still_gnt", 32'(gnt_o), 32'h2);
    check("t5_err", 32'(err_o), 0);
    req_i = '0;
    sys_rst_i = 1'b0;
    @(negedge sys_clk_i);
    sys_rst_i = 1'b1;
`endif
    stuck = 1'b0;
    repeat (3) @(negedge sys_clk_i);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
